// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencing controller for the multicycle CPU. It steps the shared
//   ALU, the unified memory port and the register file through fetch,
//   decode, execute, memory and writeback. It also counts retired
//   instructions. Unsupported encodings park the machine in TRAP until reset.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   instruction       latched IR contents, stable from DECODE onward
//   alu_zero          ALU zero flag (only used for pc_write in BRANCH)
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_we/mem_addr_source       memory port controls
//   ir_write/pc_write/pc_source          IR and PC load controls
//   alu_src_a/alu_src_b/imm_zero_extend/alu_ctrl   ALU operand and op selects
//   reg_write/reg_dst/mem_to_reg         register file write controls
//   illegal_op        sticky trap flag (high while in TRAP)
//   state             current state encoding for debug
//   instr_retired     wrapping count of completed instructions
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instruction,
  input  logic                   alu_zero,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_source,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_source,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   imm_zero_extend,
  output logic [2:0]             alu_ctrl,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   illegal_op,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_e                 state_q;
  state_e                 state_d;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic [COUNT_WIDTH-1:0] retired_d;
  logic                   retire_s;
  logic [5:0]             opcode_s;
  logic [5:0]             funct_s;

  assign opcode_s = instruction[31:26];
  assign funct_s  = instruction[5:0];

  // True for the four R-format functions the datapath implements.
  function automatic logic funct_supported(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_AND, FN_OR, FN_SUB: funct_supported = 1'b1;
      default:                       funct_supported = 1'b0;
    endcase
  endfunction

  // ALU operation for an R-format funct; only reached for supported functs.
  function automatic logic [2:0] funct_alu_ctrl(input logic [5:0] funct);
    case (funct)
      FN_ADD:  funct_alu_ctrl = ALU_ADD;
      FN_AND:  funct_alu_ctrl = ALU_AND;
      FN_OR:   funct_alu_ctrl = ALU_OR;
      FN_SUB:  funct_alu_ctrl = ALU_SUB;
      default: funct_alu_ctrl = ALU_ADD;
    endcase
  endfunction

  // Next-state, Moore outputs and retire strobe for the current state.
  always_comb begin
    state_d         = state_q;
    retire_s        = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr_source = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_source       = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    imm_zero_extend = 1'b0;
    alu_ctrl        = 3'b000;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    illegal_op      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // Fetch reads mem[PC] while the ALU forms PC+4 for the PC load.
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end

      // Branch target is computed speculatively into ALUOut here.
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode_s)
          OP_RTYPE: begin
            if (funct_supported(funct_s)) begin
              state_d = S_EXECUTE;
            end else begin
              state_d = S_TRAP;
            end
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          default:          state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        if (opcode_s == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end

      S_MEM_READ: begin
        mem_req         = 1'b1;
        mem_addr_source = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_READ;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end

      // A store retires on the edge where memory accepts it.
      S_MEM_WRITE: begin
        mem_req         = 1'b1;
        mem_we          = 1'b1;
        mem_addr_source = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEM_WRITE;
        end
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu_ctrl(funct_s);
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end

      // IMM_WB keeps the ALU inputs alive so ALUOut stays valid for the write.
      S_IMM_EXEC, S_IMM_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode_s == OP_ANDI) begin
          alu_ctrl        = ALU_AND;
          imm_zero_extend = 1'b1;
        end else begin
          alu_ctrl        = ALU_ADD;
          imm_zero_extend = 1'b0;
        end
        if (state_q == S_IMM_WB) begin
          reg_write = 1'b1;
          retire_s  = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_IMM_WB;
        end
      end

      // rs - rt drives alu_zero; the target was latched into ALUOut in DECODE.
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_source = 1'b1;
        pc_write  = alu_zero;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        illegal_op = 1'b1;
        state_d    = S_TRAP;
      end

      // Unused encodings recover to IDLE.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retire counter next value; wraps naturally at the counter width.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + COUNT_WIDTH'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state         = state_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_DEC   = 4'd2;
  localparam logic [3:0] ST_MADDR = 4'd3;
  localparam logic [3:0] ST_MREAD = 4'd4;
  localparam logic [3:0] ST_MWB   = 4'd5;
  localparam logic [3:0] ST_MWR   = 4'd6;
  localparam logic [3:0] ST_EXEC  = 4'd7;
  localparam logic [3:0] ST_ALUWB = 4'd8;
  localparam logic [3:0] ST_IEXEC = 4'd9;
  localparam logic [3:0] ST_IWB   = 4'd10;
  localparam logic [3:0] ST_BR    = 4'd11;
  localparam logic [3:0] ST_TRAP  = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        mem_ready;

  logic        mem_req, mem_we, mem_addr_source, ir_write, pc_write, pc_source;
  logic        alu_src_a, imm_zero_extend, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  logic        sm_mem_req, sm_mem_we, sm_mem_addr_source, sm_ir_write, sm_pc_write, sm_pc_source;
  logic        sm_alu_src_a, sm_imm_zero_extend, sm_reg_write, sm_reg_dst, sm_mem_to_reg, sm_illegal_op;
  logic [1:0]  sm_alu_src_b;
  logic [2:0]  sm_alu_ctrl;
  logic [3:0]  sm_state;
  logic [2:0]  sm_instr_retired;

  logic [16:0] obs_word;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] w;
    logic [31:0] cnt;
  } sb_rec_t;

  sb_rec_t     sb_q[$];
  logic [31:0] cnt_model;
  int          vectors_applied = 0;
  int          miscompares = 0;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_source(mem_addr_source), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zero_extend(imm_zero_extend), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .state(state), .instr_retired(instr_retired)
  );

  // Narrow-counter build shares the stimulus so its counter must wrap mod 8.
  multicycle_control #(.COUNT_WIDTH(3)) dut_small (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(sm_mem_req), .mem_we(sm_mem_we),
    .mem_addr_source(sm_mem_addr_source), .ir_write(sm_ir_write), .pc_write(sm_pc_write),
    .pc_source(sm_pc_source), .alu_src_a(sm_alu_src_a), .alu_src_b(sm_alu_src_b),
    .imm_zero_extend(sm_imm_zero_extend), .alu_ctrl(sm_alu_ctrl), .reg_write(sm_reg_write),
    .reg_dst(sm_reg_dst), .mem_to_reg(sm_mem_to_reg), .illegal_op(sm_illegal_op),
    .state(sm_state), .instr_retired(sm_instr_retired)
  );

  always #5 clk = ~clk;

  assign obs_word = {mem_req, mem_we, mem_addr_source, ir_write, pc_write, pc_source,
                     alu_src_a, alu_src_b, imm_zero_extend, alu_ctrl,
                     reg_write, reg_dst, mem_to_reg, illegal_op};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(
    input logic req, input logic we, input logic mas, input logic irw,
    input logic pcw, input logic pcs, input logic sa, input logic [1:0] sb,
    input logic zx, input logic [2:0] ctl, input logic rw, input logic rd,
    input logic m2r, input logic ill);
    return {req, we, mas, irw, pcw, pcs, sa, sb, zx, ctl, rw, rd, m2r, ill};
  endfunction

  function automatic logic [16:0] w_fetch(input logic rdy);
    return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b0, 2'b01, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_dec();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_maddr();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_mread();
    return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_mwb();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] w_mwr();
    return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_exec(input logic [2:0] ctl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, ctl, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_aluwb();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_imm(input logic andi, input logic wb);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, andi,
              andi ? 3'b000 : 3'b010, wb, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_br(input logic az);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, az, 1'b1, 1'b1, 2'b00, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] w_trap();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // One clock cycle: drive inputs, push the expectation, compare at negedge.
  task automatic step(input logic mr, input logic az, input logic [3:0] es, input logic [16:0] ew);
    sb_rec_t rec;
    mem_ready = mr;
    alu_zero  = az;
    sb_q.push_back('{st: es, w: ew, cnt: cnt_model});
    @(negedge clk);
    rec = sb_q.pop_front();
    check_value("state", {28'd0, state}, {28'd0, rec.st});
    check_value("outputs", {15'd0, obs_word}, {15'd0, rec.w});
    check_value("retired", instr_retired, rec.cnt);
    check_value("retired_w3", {29'd0, sm_instr_retired}, {29'd0, rec.cnt[2:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_state"}, {28'd0, state}, 32'd0);
    check_value({tag, "_outputs"}, {15'd0, obs_word}, 32'd0);
    check_value({tag, "_retired"}, instr_retired, 32'd0);
    check_value({tag, "_retired_w3"}, {29'd0, sm_instr_retired}, 32'd0);
  endtask

  // Assert reset mid-cycle, check immediate clear, hold over an edge, release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    cnt_model = 32'd0;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    check_all_zero(tag);
    reset = 1'b0;
    step(1'b1, 1'b0, ST_IDLE, 17'd0);
  endtask

  task automatic do_fetch(input logic [31:0] instr, input int waits);
    instruction = instr;
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, ST_FETCH, w_fetch(1'b0));
    step(1'b1, 1'b0, ST_FETCH, w_fetch(1'b1));
    step(1'b1, 1'b0, ST_DEC, w_dec());
  endtask

  task automatic run_rtype(input logic [31:0] instr, input logic [2:0] ctl, input int fwaits);
    do_fetch(instr, fwaits);
    step(1'b1, 1'b0, ST_EXEC, w_exec(ctl));
    step(1'b1, 1'b0, ST_ALUWB, w_aluwb());
    cnt_model++;
  endtask

  task automatic run_lw(input int waits);
    do_fetch(32'h8C220004, 0);
    step(1'b1, 1'b0, ST_MADDR, w_maddr());
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, ST_MREAD, w_mread());
    step(1'b1, 1'b0, ST_MREAD, w_mread());
    step(1'b0, 1'b0, ST_MWB, w_mwb());
    cnt_model++;
  endtask

  task automatic run_sw(input int waits);
    do_fetch(32'hAC220004, 0);
    step(1'b1, 1'b0, ST_MADDR, w_maddr());
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, ST_MWR, w_mwr());
    step(1'b1, 1'b0, ST_MWR, w_mwr());
    cnt_model++;
  endtask

  task automatic run_imm(input logic andi);
    do_fetch(andi ? 32'h30220005 : 32'h20220005, 0);
    step(1'b1, 1'b0, ST_IEXEC, w_imm(andi, 1'b0));
    step(1'b1, 1'b0, ST_IWB, w_imm(andi, 1'b1));
    cnt_model++;
  endtask

  task automatic run_beq(input logic az);
    do_fetch(32'h10220003, 0);
    step(1'b1, az, ST_BR, w_br(az));
    cnt_model++;
  endtask

  task automatic run_trap(input logic [31:0] instr);
    do_fetch(instr, 0);
    for (int i = 0; i < 3; i++) step(i[0], 1'b1, ST_TRAP, w_trap());
  endtask

  initial begin
    reset       = 1'b1;
    mem_ready   = 1'b1;
    alu_zero    = 1'b0;
    instruction = 32'd0;
    cnt_model   = 32'd0;
    #1;
    check_all_zero("reset_hold");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold2");
    reset = 1'b0;
    step(1'b1, 1'b0, ST_IDLE, 17'd0);

    run_rtype(32'h00221820, 3'b010, 0);   // add
    run_lw(3);
    run_sw(0);
    run_sw(2);
    run_rtype(32'h00221822, 3'b110, 1);   // sub, one fetch wait
    run_rtype(32'h00221824, 3'b000, 0);   // and
    run_rtype(32'h00221825, 3'b001, 2);   // or, two fetch waits
    run_imm(1'b0);
    run_imm(1'b1);
    run_beq(1'b1);
    run_beq(1'b0);
    step(1'b1, 1'b0, ST_FETCH, w_fetch(1'b1));  // count 11 settles; narrow build shows 3

    // Reset while a store is waiting on memory.
    instruction = 32'hAC220004;
    step(1'b1, 1'b0, ST_DEC, w_dec());
    step(1'b1, 1'b0, ST_MADDR, w_maddr());
    step(1'b0, 1'b0, ST_MWR, w_mwr());
    mem_ready = 1'b0;
    do_reset("reset_in_store");

    run_trap(32'hFC000000);
    do_reset("reset_after_trap_op");
    run_trap(32'h0000002A);
    do_reset("reset_after_trap_funct");
    run_rtype(32'h00221820, 3'b010, 0);
    step(1'b1, 1'b0, ST_FETCH, w_fetch(1'b1));

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle build of the CPU: a Moore state machine that steps a shared ALU, a single unified memory port and the register file through fetch, decode, execute, memory and writeback for each instruction. It decodes the opcode and funct fields of the latched instruction register. It drives per-cycle datapath selects and enables, stalls on a memory ready handshake, and counts retired instructions. Supported instructions: R-format add, and, or, sub; lw; sw; addi; andi; beq. Any other encoding traps.

## Interface
- COUNT_WIDTH, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  instruction register contents; must be stable from DECODE onward
- alu_zero  in  1  ALU zero flag, combinational from the current ALU operands
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; only meaningful with mem_req
- mem_addr_source  out  1  memory address select: 0 = PC, 1 = ALUOut register
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- pc_source  out  1  PC input select: 0 = live ALU result, 1 = ALUOut register
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register rs
- alu_src_b  out  2  ALU B select: 00 = register rt, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2
- imm_zero_extend  out  1  1 = zero-extend the immediate, 0 = sign-extend it
- alu_ctrl  out  3  010 add, 000 and, 001 or, 110 sub
- reg_write  out  1  register file write enable
- reg_dst  out  1  write address select: 0 = rt [20:16], 1 = rd [15:11]
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = memory data register
- illegal_op  out  1  sticky trap flag
- state  out  4  current state encoding, for debug
- instr_retired  out  COUNT_WIDTH  count of completed instructions

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, IMM_EXEC=9, IMM_WB=10, BRANCH=11, TRAP=12. Encodings 13–15 go to IDLE.
- Default: every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, mem_addr_source=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_source=0, next DECODE.
  - Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010, which computes the branch target into ALUOut. Next state by opcode [31:26]:
  - 000000 with funct [5:0] in {100000, 100100, 100101, 100010} → EXECUTE.
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 001000 (addi) or 001100 (andi) → IMM_EXEC.
  - 000100 (beq) → BRANCH.
  - Any other opcode, or opcode 000000 with any other funct → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, mem_addr_source=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, mem_addr_source=1. Hold until mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct (100000→010, 100100→000, 100101→001, 100010→110). Next ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10; alu_ctrl=010 for addi, 000 for andi; imm_zero_extend=1 for andi only. Next IMM_WB.
- IMM_WB: same enables as IMM_EXEC, plus reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_source=1, pc_write=alu_zero. Next FETCH.
- TRAP: illegal_op=1, all other outputs 0. Stays in TRAP until reset.
- instr_retired increments by 1 on every clock edge that leaves MEM_WB, ALU_WB, IMM_WB or BRANCH, or leaves MEM_WRITE with mem_ready=1. Wraps modulo 2^COUNT_WIDTH. Never increments in TRAP.

## Timing
- Asserting reset immediately forces state=IDLE, instr_retired=0, illegal_op=0 and all outputs 0. This applies mid-instruction and mid-memory-access; no write completes.
- The first FETCH occurs on the first clock edge after reset deasserts.
- All outputs except pc_write in BRANCH are pure functions of state and instruction. pc_write in BRANCH also depends on alu_zero.
- mem_ready is sampled only on edges where mem_req=1 and is ignored otherwise. Memory may hold mem_ready high continuously, giving zero-wait accesses.
- Zero-wait latencies, FETCH through the last state, in cycles: R-type 4, addi/andi 4, beq 3, sw 4, lw 5. Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds one.
- instruction is read only in DECODE through the final state, after the IR has been loaded.

## Test plan
- Reset held, then released, mem_ready=1 → state goes 0 then 1; mem_req=1 only from the FETCH cycle onward; every output is 0 during reset.
- add (0x00221820), mem_ready=1 → states 1,2,7,8,1; alu_ctrl=010 in EXECUTE; reg_write=1 with reg_dst=1 in ALU_WB; instr_retired 0→1.
- lw (0x8C220004) with mem_ready low for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles; MEM_WB has mem_to_reg=1; total 8 cycles.
- beq (0x10220003): alu_zero=1 → pc_write=1 and pc_source=1 in BRANCH. Repeat with alu_zero=0 → pc_write=0. Both cases retire.
- Opcode 0x3F, then R-type funct 0x2A → TRAP, illegal_op=1 sticky, no further mem_req, counter frozen; only reset clears it.
- Reset asserted during MEM_WRITE with mem_ready=0 → mem_we drops immediately; instr_retired=0. Separately, preload the counter near 2^COUNT_WIDTH−1 (small COUNT_WIDTH build) and retire past it → counter wraps to 0.
